gpu_stencil_ctrl: RTL and testbench
===================================

GPU_STENCIL_CTRL -- requirements
Module: gpu_stencil_ctrl

Interface
REQ-001 The block SHALL expose one clock and one reset: clk_i in 1 (the single clock, all state on its rising edge); rst_ni in 1 (asynchronous, active-low reset).
REQ-002 The block SHALL expose these pixel-pipe ports:
- pp_rd_req_i in 1: read request
- pp_rd_addr_i in 15: read address
- pp_rd_tag_i in 4: requester tag
- pp_rd_ready_o out 1: read accepted this cycle
- pp_rd_valid_o out 1: read data valid
- pp_rd_data_o out 16: read data
- pp_rd_tag_o out 4: returned tag
REQ-003 The block SHALL expose these pixel-pipe write ports:
- pp_wr_req_i in 1: write request
- pp_wr_addr_i in 15: write address
- pp_wr_mask_i in 16: bit mask
- pp_wr_value_i in 16: write data
- pp_wr_ready_o out 1: write accepted this cycle
REQ-004 The block SHALL expose these clear ports:
- clr_start_i in 1: start pulse
- clr_value_i in 16: fill value
- clr_busy_o out 1: clear in progress
- clr_done_o out 1: one-cycle completion pulse
REQ-005 The block SHALL expose these cache-side ports:
- stencil_rd_req_o out 1; stencil_rd_addr_o out 15
- stencil_wr_req_o out 1; stencil_wr_addr_o out 15
- stencil_wr_mask_o out 16; stencil_wr_value_o out 16
- stencil_rd_value_i in 16: data, 1 cycle after the read request
- stencil_error_i in 1: cache misuse flag
- err_sticky_o out 1; err_count_o out 8

Function
REQ-006 Bank ID SHALL be {addr[7:6], addr[0]}; the cache faults on writes to the same bank in consecutive cycles.
REQ-007 A write SHALL issue only when no write issued in the previous cycle, or the previous write's bank ID differs (write hazard); otherwise pp_wr_ready_o=0 and the request is held by the client.
REQ-008 pp_wr_ready_o SHALL be combinational: pp_wr_req_i & ~hazard & ~clr_busy_o; when it is 1, the cache write outputs SHALL equal the pp_wr_* inputs in the same cycle.
REQ-009 A read SHALL stall (pp_rd_ready_o=0) under either condition:
- its address equals the write address issued in the same cycle;
- its address equals the write address issued in the previous cycle and that write's mask != 16'hFFFF (delayed commit).
REQ-010 Reads SHALL also stall while clr_busy_o=1; otherwise, when ready, stencil_rd_req_o=1 with stencil_rd_addr_o=pp_rd_addr_i in the same cycle.
REQ-011 One cycle after an accepted read, the block SHALL drive pp_rd_valid_o=1 for exactly one cycle, with pp_rd_data_o=stencil_rd_value_i and pp_rd_tag_o=the accepted tag; read throughput SHALL be one per cycle.
REQ-012 A read and a write MAY issue in the same cycle when neither hazard applies.
REQ-013 The clear FSM SHALL have the states IDLE, CLEAR and DONE:
- IDLE->CLEAR on clr_start_i, capturing clr_value_i, with counter=0;
- CLEAR->DONE after the write to address 32767 issues;
- DONE->IDLE unconditionally.
REQ-014 In CLEAR, each cycle the write hazard permits, the block SHALL issue a write of {counter, mask 16'hFFFF, captured value} and increment the 15-bit counter; a hazard cycle SHALL hold the counter.
REQ-015 clr_busy_o SHALL be 1 in CLEAR, and clr_done_o SHALL be 1 only in DONE.
REQ-016 clr_start_i SHALL be ignored outside IDLE; a 15-bit counter wrap without the DONE transition is forbidden.
REQ-017 Under normal flow a full clear SHALL take 32768 issue cycles: consecutive addresses toggle addr[0], so there is no self-hazard.
REQ-018 A pixel write accepted in the cycle before CLEAR entry SHALL be honoured by the hazard check on the first clear write.

Reset
REQ-019 While rst_ni=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and the write history (valid, bank, address, mask-full) SHALL be cleared.
REQ-020 Reset asserted during CLEAR SHALL abort the clear, with no clr_done_o pulse.
REQ-021 An in-flight read SHALL produce no pp_rd_valid_o after reset.

Configuration
REQ-022 With the STENCIL_CTRL_ERRCNT_EN macro defined, err_sticky_o SHALL set on any cycle with stencil_error_i=1 and stay set until reset.
REQ-023 With STENCIL_CTRL_ERRCNT_EN defined, err_count_o SHALL increment on each such cycle, saturating at 255.
REQ-024 With STENCIL_CTRL_ERRCNT_EN undefined, err_sticky_o and err_count_o SHALL be tied to 0 and stencil_error_i SHALL be unused.

Verification
REQ-025 Bench SHALL cover write back-to-back hazard: writes to 0x0000 then 0x0002 (both bank 0) -> second ready=0 for one cycle, issued next; stencil_error_i never 1.
REQ-026 Bench SHALL cover different-bank throughput: writes 0x0000 then 0x0001 -> both issue in consecutive cycles.
REQ-027 Bench SHALL cover masked read-after-write: write 0x0123 mask 0x00FF, then read 0x0123 next cycle -> read stalls one cycle and returns the merged value.
REQ-028 Bench SHALL cover clear: clr_start_i with value 0xA5A5 -> busy for 32768 cycles, one done pulse, random reads all 0xA5A5, pp requests stalled throughout.
REQ-029 Bench SHALL cover reset mid-clear: rst_ni low at counter 1000 -> outputs 0, no done pulse; a new clear runs from address 0.
REQ-030 Bench SHALL cover the error counter (macro defined): 300 error cycles forced -> err_count_o=255, err_sticky_o=1.

Source files
------------

// File: rtl/gpu_stencil_ctrl.sv
// gpu_stencil_ctrl
// Front end for a banked stencil cache. It feeds pixel-pipe reads and writes
// to the cache, and it keeps the cache away from two kinds of misuse:
//   - two writes to the same bank in consecutive cycles;
//   - a read that would see a write that has not yet committed.
// It also runs a clear engine that fills all 32768 entries with one value.
//
// Ports
//   clk_i, rst_ni          clock; asynchronous active-low reset
//   pp_rd_*                pixel-pipe read request, ready, and tagged return
//   pp_wr_*                pixel-pipe masked write request and ready
//   clr_*                  clear start/value, busy level, done pulse
//   stencil_rd_*/wr_*      cache-side read and write issue; read data returns
//                          one cycle after the request
//   stencil_error_i        cache misuse flag
//   err_sticky_o/count_o   error flag and count (zero unless enabled)
//
// Build option
//   STENCIL_CTRL_ERRCNT_EN  when defined, err_sticky_o records any cycle with
//                           stencil_error_i high, and err_count_o counts those
//                           cycles, saturating at 255. When it is not defined,
//                           both outputs are tied to zero.
//
// Clear FSM
//   state    | meaning
//   IDLE     | pixel traffic flows; clr_start_i is accepted
//   CLEAR    | one fill write per hazard-free cycle; pixel traffic stalled
//   DONE     | one-cycle completion pulse, then back to IDLE

module gpu_stencil_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        pp_rd_req_i,
  input  logic [14:0] pp_rd_addr_i,
  input  logic [3:0]  pp_rd_tag_i,
  output logic        pp_rd_ready_o,
  output logic        pp_rd_valid_o,
  output logic [15:0] pp_rd_data_o,
  output logic [3:0]  pp_rd_tag_o,

  input  logic        pp_wr_req_i,
  input  logic [14:0] pp_wr_addr_i,
  input  logic [15:0] pp_wr_mask_i,
  input  logic [15:0] pp_wr_value_i,
  output logic        pp_wr_ready_o,

  input  logic        clr_start_i,
  input  logic [15:0] clr_value_i,
  output logic        clr_busy_o,
  output logic        clr_done_o,

  output logic        stencil_rd_req_o,
  output logic [14:0] stencil_rd_addr_o,
  output logic        stencil_wr_req_o,
  output logic [14:0] stencil_wr_addr_o,
  output logic [15:0] stencil_wr_mask_o,
  output logic [15:0] stencil_wr_value_o,
  input  logic [15:0] stencil_rd_value_i,
  input  logic        stencil_error_i,
  output logic        err_sticky_o,
  output logic [7:0]  err_count_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [15:0] clr_val_q, clr_val_d;

  // History of the write issued in the previous cycle
  logic        hist_vld_q;
  logic [2:0]  hist_bank_q;
  logic [14:0] hist_addr_q;
  logic        hist_full_q;

  logic        rd_vld_q;
  logic [3:0]  rd_tag_q;

  logic        busy;
  logic [14:0] wr_addr;
  logic [15:0] wr_mask;
  logic [15:0] wr_value;
  logic [2:0]  wr_bank;
  logic        hazard;
  logic        wr_pp, wr_clr, wr_issue;
  logic        rd_stall, rd_go;

  assign busy = (state_q == ST_CLEAR);

  // Only one source may write at a time: the clear engine while busy,
  // otherwise the pixel pipe.
  assign wr_addr  = busy ? cnt_q : pp_wr_addr_i;
  assign wr_mask  = busy ? 16'hFFFF : pp_wr_mask_i;
  assign wr_value = busy ? clr_val_q : pp_wr_value_i;
  assign wr_bank  = {wr_addr[7:6], wr_addr[0]};

  assign hazard   = hist_vld_q & (wr_bank == hist_bank_q);
  assign wr_pp    = pp_wr_req_i & ~hazard & ~busy;
  assign wr_clr   = busy & ~hazard;
  assign wr_issue = wr_pp | wr_clr;

  // A partial-mask write commits one cycle late, so the following cycle
  // must not read that address either.
  assign rd_stall = busy
                  | (wr_issue & (pp_rd_addr_i == wr_addr))
                  | (hist_vld_q & ~hist_full_q & (pp_rd_addr_i == hist_addr_q));
  assign rd_go    = pp_rd_req_i & ~rd_stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_val_d = clr_val_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start_i) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          clr_val_d = clr_value_i;
        end
      end
      ST_CLEAR: begin
        if (wr_clr) begin
          cnt_d = cnt_q + 15'd1;
          if (cnt_q == 15'h7FFF) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_val_q   <= '0;
      hist_vld_q  <= 1'b0;
      hist_bank_q <= '0;
      hist_addr_q <= '0;
      hist_full_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_val_q   <= clr_val_d;
      hist_vld_q  <= wr_issue;
      hist_bank_q <= wr_bank;
      hist_addr_q <= wr_addr;
      hist_full_q <= (wr_mask == 16'hFFFF);
      rd_vld_q    <= rd_go;
      rd_tag_q    <= pp_rd_tag_i;
    end
  end

  // Combinational handshakes are gated by reset so that every output is
  // quiet while reset is held, even when clients keep requesting.
  assign pp_wr_ready_o      = rst_ni & wr_pp;
  assign pp_rd_ready_o      = rst_ni & rd_go;
  assign stencil_wr_req_o   = rst_ni & wr_issue;
  assign stencil_wr_addr_o  = stencil_wr_req_o ? wr_addr  : '0;
  assign stencil_wr_mask_o  = stencil_wr_req_o ? wr_mask  : '0;
  assign stencil_wr_value_o = stencil_wr_req_o ? wr_value : '0;
  assign stencil_rd_req_o   = pp_rd_ready_o;
  assign stencil_rd_addr_o  = pp_rd_ready_o ? pp_rd_addr_i : '0;

  assign pp_rd_valid_o = rd_vld_q;
  assign pp_rd_data_o  = rd_vld_q ? stencil_rd_value_i : '0;
  assign pp_rd_tag_o   = rd_vld_q ? rd_tag_q : '0;

  assign clr_busy_o = busy;
  assign clr_done_o = (state_q == ST_DONE);

`ifdef STENCIL_CTRL_ERRCNT_EN
  logic       err_sticky_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (stencil_error_i) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_sticky_o = err_sticky_q;
  assign err_count_o  = err_cnt_q;
`else
  logic unused_err;
  assign unused_err   = stencil_error_i;
  assign err_sticky_o = 1'b0;
  assign err_count_o  = '0;
`endif

endmodule

// File: tb/tb_gpu_stencil_ctrl.sv
module tb_gpu_stencil_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pp_rd_req_i;
  logic [14:0] pp_rd_addr_i;
  logic [3:0]  pp_rd_tag_i;
  logic        pp_rd_ready_o, pp_rd_valid_o;
  logic [15:0] pp_rd_data_o;
  logic [3:0]  pp_rd_tag_o;
  logic        pp_wr_req_i;
  logic [14:0] pp_wr_addr_i;
  logic [15:0] pp_wr_mask_i, pp_wr_value_i;
  logic        pp_wr_ready_o;
  logic        clr_start_i;
  logic [15:0] clr_value_i;
  logic        clr_busy_o, clr_done_o;
  logic        stencil_rd_req_o;
  logic [14:0] stencil_rd_addr_o;
  logic        stencil_wr_req_o;
  logic [14:0] stencil_wr_addr_o;
  logic [15:0] stencil_wr_mask_o, stencil_wr_value_o;
  logic [15:0] stencil_rd_value_i = '0;
  logic        stencil_error_i;
  logic        err_sticky_o;
  logic [7:0]  err_count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  gpu_stencil_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pp_rd_req_i(pp_rd_req_i), .pp_rd_addr_i(pp_rd_addr_i), .pp_rd_tag_i(pp_rd_tag_i),
    .pp_rd_ready_o(pp_rd_ready_o), .pp_rd_valid_o(pp_rd_valid_o),
    .pp_rd_data_o(pp_rd_data_o), .pp_rd_tag_o(pp_rd_tag_o),
    .pp_wr_req_i(pp_wr_req_i), .pp_wr_addr_i(pp_wr_addr_i), .pp_wr_mask_i(pp_wr_mask_i),
    .pp_wr_value_i(pp_wr_value_i), .pp_wr_ready_o(pp_wr_ready_o),
    .clr_start_i(clr_start_i), .clr_value_i(clr_value_i),
    .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .stencil_rd_req_o(stencil_rd_req_o), .stencil_rd_addr_o(stencil_rd_addr_o),
    .stencil_wr_req_o(stencil_wr_req_o), .stencil_wr_addr_o(stencil_wr_addr_o),
    .stencil_wr_mask_o(stencil_wr_mask_o), .stencil_wr_value_o(stencil_wr_value_o),
    .stencil_rd_value_i(stencil_rd_value_i), .stencil_error_i(stencil_error_i),
    .err_sticky_o(err_sticky_o), .err_count_o(err_count_o)
  );

  // Cache model: full-mask writes commit at the issuing edge, partial-mask
  // writes one edge later; reads sample memory before that edge's commits.
  logic [15:0] mem [0:32767];
  bit          mem_init_done = 1'b0;
  logic        c_rd = 1'b0, c_wr = 1'b0;
  logic [14:0] c_rd_a, c_wr_a;
  logic [15:0] c_wr_m, c_wr_v;
  logic        pend_v = 1'b0;
  logic [14:0] pend_a;
  logic [15:0] pend_m, pend_val;
  logic        prev_wr = 1'b0;
  logic [2:0]  prev_bank = '0;
  int          model_err = 0;

  always @(negedge clk_i) begin
    c_rd   = stencil_rd_req_o;
    c_rd_a = stencil_rd_addr_o;
    c_wr   = stencil_wr_req_o;
    c_wr_a = stencil_wr_addr_o;
    c_wr_m = stencil_wr_mask_o;
    c_wr_v = stencil_wr_value_o;
  end

  always @(posedge clk_i) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32768; i++) mem[i] = '0;
      mem_init_done = 1'b1;
    end
    if (c_rd) stencil_rd_value_i = mem[c_rd_a];
    if (pend_v) begin
      mem[pend_a] = (mem[pend_a] & ~pend_m) | (pend_val & pend_m);
      pend_v = 1'b0;
    end
    if (c_wr) begin
      if (prev_wr && prev_bank == {c_wr_a[7:6], c_wr_a[0]}) model_err++;
      if (c_wr_m == 16'hFFFF) mem[c_wr_a] = c_wr_v;
      else begin
        pend_v = 1'b1; pend_a = c_wr_a; pend_m = c_wr_m; pend_val = c_wr_v;
      end
    end
    prev_wr   = c_wr;
    prev_bank = {c_wr_a[7:6], c_wr_a[0]};
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    pp_rd_req_i = 0; pp_rd_addr_i = '0; pp_rd_tag_i = '0;
    pp_wr_req_i = 0; pp_wr_addr_i = '0; pp_wr_mask_i = '0; pp_wr_value_i = '0;
    clr_start_i = 0; clr_value_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    pp_rd_req_i = 1; pp_rd_addr_i = 15'h0010; pp_rd_tag_i = 4'h3;
    pp_wr_req_i = 1; pp_wr_addr_i = 15'h0020; pp_wr_mask_i = 16'hFFFF; pp_wr_value_i = 16'hBEEF;
    clr_start_i = 1; clr_value_i = 16'h0001; stencil_error_i = 1;
    repeat (3) @(posedge clk_i);
    #3;
    total++; if (pp_wr_ready_o !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%0b exp=0", pp_wr_ready_o); end
    total++; if (pp_rd_ready_o !== 1'b0) begin bad++; $display("FAIL rst_rd_ready got=%0b exp=0", pp_rd_ready_o); end
    total++; if ({stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_mask_o, stencil_wr_value_o} !== '0) begin
      bad++; $display("FAIL rst_cache_wr got=%0b/%h/%h/%h exp=0", stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_mask_o, stencil_wr_value_o); end
    total++; if ({stencil_rd_req_o, stencil_rd_addr_o} !== '0) begin
      bad++; $display("FAIL rst_cache_rd got=%0b/%h exp=0", stencil_rd_req_o, stencil_rd_addr_o); end
    total++; if ({clr_busy_o, clr_done_o, pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o} !== '0) begin
      bad++; $display("FAIL rst_status got busy=%0b done=%0b vld=%0b data=%h tag=%h exp=0", clr_busy_o, clr_done_o, pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o); end
    total++; if ({err_sticky_o, err_count_o} !== '0) begin
      bad++; $display("FAIL rst_err got sticky=%0b cnt=%0d exp=0", err_sticky_o, err_count_o); end
    idle_inputs(); stencil_error_i = 0;
    #1 rst_ni = 1;
    tick(); tick();
    #2;
    total++; if (clr_busy_o !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%0b exp=0", clr_busy_o); end
  endtask

  task automatic test_back_to_back();
    tick();
    pp_wr_req_i = 1; pp_wr_addr_i = 15'h0000; pp_wr_mask_i = 16'hFFFF; pp_wr_value_i = 16'h1111;
    #2;
    total++; if ({pp_wr_ready_o, stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_value_o} !== {1'b1, 1'b1, 15'h0000, 16'h1111}) begin
      bad++; $display("FAIL b2b_first got rdy=%0b req=%0b a=%h v=%h exp=1/1/0000/1111", pp_wr_ready_o, stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_value_o); end
    tick();
    pp_wr_addr_i = 15'h0002; pp_wr_value_i = 16'h2222;
    #2;
    total++; if ({pp_wr_ready_o, stencil_wr_req_o} !== 2'b00) begin
      bad++; $display("FAIL b2b_hazard got rdy=%0b req=%0b exp=0/0", pp_wr_ready_o, stencil_wr_req_o); end
    tick();
    #2;
    total++; if ({pp_wr_ready_o, stencil_wr_addr_o, stencil_wr_value_o} !== {1'b1, 15'h0002, 16'h2222}) begin
      bad++; $display("FAIL b2b_retry got rdy=%0b a=%h v=%h exp=1/0002/2222", pp_wr_ready_o, stencil_wr_addr_o, stencil_wr_value_o); end
    tick();
    pp_wr_req_i = 0;
    tick();
    total++; if (model_err !== 0) begin bad++; $display("FAIL b2b_cache_err got=%0d exp=0", model_err); end
  endtask

  task automatic test_diff_bank();
    tick();
    pp_wr_req_i = 1; pp_wr_addr_i = 15'h0000; pp_wr_mask_i = 16'hFFFF; pp_wr_value_i = 16'h3333;
    #2;
    total++; if (pp_wr_ready_o !== 1'b1) begin bad++; $display("FAIL diff_first got=%0b exp=1", pp_wr_ready_o); end
    tick();
    pp_wr_addr_i = 15'h0001; pp_wr_value_i = 16'h4444;
    pp_rd_req_i = 1; pp_rd_addr_i = 15'h0002; pp_rd_tag_i = 4'h5;
    #2;
    total++; if (pp_wr_ready_o !== 1'b1) begin bad++; $display("FAIL diff_second got=%0b exp=1", pp_wr_ready_o); end
    total++; if ({pp_rd_ready_o, stencil_rd_req_o, stencil_rd_addr_o} !== {1'b1, 1'b1, 15'h0002}) begin
      bad++; $display("FAIL diff_par_read got rdy=%0b req=%0b a=%h exp=1/1/0002", pp_rd_ready_o, stencil_rd_req_o, stencil_rd_addr_o); end
    tick();
    pp_wr_req_i = 0; pp_rd_req_i = 0;
    #2;
    total++; if ({pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o} !== {1'b1, 16'h2222, 4'h5}) begin
      bad++; $display("FAIL diff_rd_return got vld=%0b d=%h t=%h exp=1/2222/5", pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o); end
    tick();
    #2;
    total++; if (pp_rd_valid_o !== 1'b0) begin bad++; $display("FAIL diff_rd_single got=%0b exp=0", pp_rd_valid_o); end
    total++; if (model_err !== 0) begin bad++; $display("FAIL diff_cache_err got=%0d exp=0", model_err); end
  endtask

  task automatic test_masked_raw();
    tick();
    pp_wr_req_i = 1; pp_wr_addr_i = 15'h0123; pp_wr_mask_i = 16'hFFFF; pp_wr_value_i = 16'hABCD;
    tick();
    pp_wr_req_i = 0;
    tick();
    pp_wr_req_i = 1; pp_wr_mask_i = 16'h00FF; pp_wr_value_i = 16'h1234;
    #2;
    total++; if (pp_wr_ready_o !== 1'b1) begin bad++; $display("FAIL raw_wr got=%0b exp=1", pp_wr_ready_o); end
    tick();
    pp_wr_req_i = 0;
    pp_rd_req_i = 1; pp_rd_addr_i = 15'h0123; pp_rd_tag_i = 4'h7;
    #2;
    total++; if (pp_rd_ready_o !== 1'b0) begin bad++; $display("FAIL raw_stall got=%0b exp=0", pp_rd_ready_o); end
    tick();
    #2;
    total++; if (pp_rd_ready_o !== 1'b1) begin bad++; $display("FAIL raw_accept got=%0b exp=1", pp_rd_ready_o); end
    tick();
    pp_rd_req_i = 0;
    #2;
    total++; if ({pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o} !== {1'b1, 16'hAB34, 4'h7}) begin
      bad++; $display("FAIL raw_merged got vld=%0b d=%h t=%h exp=1/AB34/7", pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o); end
    tick();
    pp_wr_req_i = 1; pp_wr_addr_i = 15'h0200; pp_wr_mask_i = 16'hFFFF; pp_wr_value_i = 16'h5A5A;
    pp_rd_req_i = 1; pp_rd_addr_i = 15'h0200; pp_rd_tag_i = 4'h3;
    #2;
    total++; if ({pp_wr_ready_o, pp_rd_ready_o} !== 2'b10) begin
      bad++; $display("FAIL raw_same_cycle got wr=%0b rd=%0b exp=1/0", pp_wr_ready_o, pp_rd_ready_o); end
    tick();
    pp_wr_req_i = 0;
    #2;
    total++; if (pp_rd_ready_o !== 1'b1) begin bad++; $display("FAIL raw_full_next got=%0b exp=1", pp_rd_ready_o); end
    tick();
    pp_rd_req_i = 0;
    #2;
    total++; if ({pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o} !== {1'b1, 16'h5A5A, 4'h3}) begin
      bad++; $display("FAIL raw_full_data got vld=%0b d=%h t=%h exp=1/5A5A/3", pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o); end
    tick();
  endtask

  task automatic test_clear();
    int busy_cnt = 0, done_cnt = 0, stall_viol = 0, seq_err = 0, after = 0;
    int last_busy_c = -1, done_c = -1;
    int err0 = model_err;
    logic [14:0] exp_a = '0;
    tick();
    clr_start_i = 1; clr_value_i = 16'hA5A5;
    #2;
    total++; if (clr_busy_o !== 1'b0) begin bad++; $display("FAIL clr_start_cycle_busy got=%0b exp=0", clr_busy_o); end
    tick();
    clr_start_i = 0;
    for (int c = 0; c < 33000; c++) begin
      pp_rd_req_i = (done_cnt == 0); pp_rd_addr_i = 15'($urandom_range(32767));
      pp_wr_req_i = (done_cnt == 0); pp_wr_addr_i = 15'($urandom_range(32767));
      pp_wr_mask_i = 16'h0000; pp_wr_value_i = 16'($urandom_range(65535));
      clr_start_i = (c == 100); clr_value_i = 16'h0F0F;
      #2;
      if (clr_busy_o) begin
        busy_cnt++;
        last_busy_c = c;
        if (pp_rd_ready_o || pp_wr_ready_o) stall_viol++;
        if (!stencil_wr_req_o || stencil_wr_addr_o != exp_a || stencil_wr_mask_o != 16'hFFFF
            || stencil_wr_value_o != 16'hA5A5) seq_err++;
        else exp_a = exp_a + 15'd1;
      end
      if (clr_done_o) begin done_cnt++; done_c = c; end
      if (done_cnt > 0) after++;
      tick();
      if (after > 4) break;
    end
    idle_inputs();
    total++; if (busy_cnt !== 32768) begin bad++; $display("FAIL clr_busy_cycles got=%0d exp=32768", busy_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL clr_done_pulses got=%0d exp=1", done_cnt); end
    total++; if (done_c !== last_busy_c + 1) begin bad++; $display("FAIL clr_done_timing got=%0d exp=%0d", done_c, last_busy_c + 1); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL clr_pp_stall got=%0d exp=0", stall_viol); end
    total++; if (seq_err !== 0) begin bad++; $display("FAIL clr_sequence got=%0d exp=0", seq_err); end
    total++; if (model_err !== err0) begin bad++; $display("FAIL clr_cache_err got=%0d exp=%0d", model_err, err0); end
    tick(); tick();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        pp_rd_req_i = 1; pp_rd_addr_i = 15'($urandom_range(32767)); pp_rd_tag_i = 4'(i);
      end else pp_rd_req_i = 0;
      #2;
      if (i < 8) begin
        total++; if (pp_rd_ready_o !== 1'b1) begin bad++; $display("FAIL clr_rd_ready_%0d got=%0b exp=1", i, pp_rd_ready_o); end
      end
      if (i > 0) begin
        total++; if ({pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o} !== {1'b1, 16'hA5A5, 4'(i - 1)}) begin
          bad++; $display("FAIL clr_rd_data_%0d got vld=%0b d=%h t=%h exp=1/A5A5/%h", i - 1, pp_rd_valid_o, pp_rd_data_o, pp_rd_tag_o, 4'(i - 1)); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    bit hit = 0;
    int done_seen = 0;
    tick();
    pp_rd_req_i = 1; pp_rd_addr_i = 15'h0005; pp_rd_tag_i = 4'h9;
    #2;
    total++; if (pp_rd_ready_o !== 1'b1) begin bad++; $display("FAIL inflight_accept got=%0b exp=1", pp_rd_ready_o); end
    rst_ni = 0; pp_rd_req_i = 0;
    @(posedge clk_i); #3;
    total++; if (pp_rd_valid_o !== 1'b0) begin bad++; $display("FAIL inflight_valid got=%0b exp=0", pp_rd_valid_o); end
    rst_ni = 1;
    tick(); #2;
    total++; if (pp_rd_valid_o !== 1'b0) begin bad++; $display("FAIL inflight_after got=%0b exp=0", pp_rd_valid_o); end
    tick();
    clr_start_i = 1; clr_value_i = 16'h1234;
    tick();
    clr_start_i = 0;
    for (int c = 0; c < 1100; c++) begin
      #2;
      if (stencil_wr_req_o && clr_busy_o && stencil_wr_addr_o == 15'd1000) begin hit = 1; break; end
      tick();
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL mid_reach_1000 got=%0b exp=1", hit); end
    rst_ni = 0;
    #1;
    total++; if ({clr_busy_o, clr_done_o, stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_value_o} !== '0) begin
      bad++; $display("FAIL mid_rst_outputs got busy=%0b done=%0b req=%0b a=%h v=%h exp=0", clr_busy_o, clr_done_o, stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_value_o); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #3;
      if (clr_done_o) done_seen++;
    end
    rst_ni = 1;
    for (int c = 0; c < 5; c++) begin
      tick(); #2;
      if (clr_done_o || clr_busy_o) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
    tick();
    pp_wr_req_i = 1; pp_wr_addr_i = 15'h0004; pp_wr_mask_i = 16'hFFFF; pp_wr_value_i = 16'h7777;
    clr_start_i = 1; clr_value_i = 16'h5555;
    #2;
    total++; if (pp_wr_ready_o !== 1'b1) begin bad++; $display("FAIL entry_pp_write got=%0b exp=1", pp_wr_ready_o); end
    tick();
    pp_wr_req_i = 0; clr_start_i = 0;
    #2;
    total++; if ({clr_busy_o, stencil_wr_req_o} !== 2'b10) begin
      bad++; $display("FAIL entry_hazard got busy=%0b req=%0b exp=1/0", clr_busy_o, stencil_wr_req_o); end
    tick(); #2;
    total++; if ({stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_value_o} !== {1'b1, 15'd0, 16'h5555}) begin
      bad++; $display("FAIL restart_addr0 got req=%0b a=%h v=%h exp=1/0000/5555", stencil_wr_req_o, stencil_wr_addr_o, stencil_wr_value_o); end
    tick(); #2;
    total++; if ({stencil_wr_req_o, stencil_wr_addr_o} !== {1'b1, 15'd1}) begin
      bad++; $display("FAIL restart_addr1 got req=%0b a=%h exp=1/0001", stencil_wr_req_o, stencil_wr_addr_o); end
    rst_ni = 0;
    tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic test_err_counter();
`ifdef STENCIL_CTRL_ERRCNT_EN
    tick();
    stencil_error_i = 1;
    tick(); #2;
    total++; if ({err_sticky_o, err_count_o} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL err_first got sticky=%0b cnt=%0d exp=1/1", err_sticky_o, err_count_o); end
    for (int k = 1; k < 300; k++) begin
      tick();
      if (k == 199) begin
        #2;
        total++; if (err_count_o !== 8'd200) begin bad++; $display("FAIL err_mid got=%0d exp=200", err_count_o); end
      end
    end
    stencil_error_i = 0;
    tick(); tick(); #2;
    total++; if ({err_sticky_o, err_count_o} !== {1'b1, 8'd255}) begin
      bad++; $display("FAIL err_saturate got sticky=%0b cnt=%0d exp=1/255", err_sticky_o, err_count_o); end
`else
    tick();
    stencil_error_i = 1;
    repeat (5) tick();
    #2;
    total++; if ({err_sticky_o, err_count_o} !== '0) begin
      bad++; $display("FAIL err_tied got sticky=%0b cnt=%0d exp=0/0", err_sticky_o, err_count_o); end
    stencil_error_i = 0;
    tick();
`endif
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    stencil_error_i = 0;
    test_reset();
    test_back_to_back();
    test_diff_bank();
    test_masked_raw();
    test_clear();
    test_reset_mid_clear();
    test_err_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
